// File: rtl/intersection_phase_arbiter_pkg.sv
// Shared phase encodings, grant one-hot constants and lamp decode for the intersection arbiter.
package intersection_phase_arbiter_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN   = 3'd0,
    MAIN_YELLOW  = 3'd1,
    ALL_RED_A    = 3'd2,
    CROSS_GREEN  = 3'd3,
    CROSS_YELLOW = 3'd4,
    ALL_RED_B    = 3'd5
  } phase_t;

  localparam logic [2:0] GRANT_NONE = 3'b000;
  localparam logic [2:0] GRANT_CAR  = 3'b001;
  localparam logic [2:0] GRANT_PED  = 3'b010;
  localparam logic [2:0] GRANT_EMER = 3'b100;

  typedef struct packed {
    logic r1;
    logic y1;
    logic g1;
    logic r2;
    logic y2;
    logic g2;
  } lamps_t;

  // Lamp pattern for a phase; anything unexpected shows all red.
  function automatic lamps_t lamp_decode(input phase_t p);
    lamps_t l;
    l = '0;
    case (p)
      MAIN_GREEN:   begin l.g1 = 1'b1; l.r2 = 1'b1; end
      MAIN_YELLOW:  begin l.y1 = 1'b1; l.r2 = 1'b1; end
      CROSS_GREEN:  begin l.r1 = 1'b1; l.g2 = 1'b1; end
      CROSS_YELLOW: begin l.r1 = 1'b1; l.y2 = 1'b1; end
      default:      begin l.r1 = 1'b1; l.r2 = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_phase_arbiter_tick_gen.sv
// Timing-tick prescaler: one-cycle tick every TICK_DIV clocks, restarting from zero on reset.
module intersection_phase_arbiter_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/intersection_phase_arbiter.sv
// Two-road intersection phase sequencer with emergency preemption and car/ped round-robin
// arbitration of cross-street right-of-way.
module intersection_phase_arbiter
  import intersection_phase_arbiter_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned MAIN_MIN_T  = 10,
  parameter int unsigned YELLOW_T    = 3,
  parameter int unsigned ALLRED_T    = 1,
  parameter int unsigned CAR_GREEN_T = 8,
  parameter int unsigned PED_WALK_T  = 6,
  parameter int unsigned EMER_T      = 12,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_sensor,
  input  logic       ped_sensor,
  input  logic       emer_signal,
  output logic       R1,
  output logic       Y1,
  output logic       G1,
  output logic       R2,
  output logic       Y2,
  output logic       G2,
  output logic       walk,
  output logic [2:0] grant,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LD_MAIN   = CNT_W'(MAIN_MIN_T - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] LD_CAR    = CNT_W'(CAR_GREEN_T - 1);
  localparam logic [CNT_W-1:0] LD_PED    = CNT_W'(PED_WALK_T - 1);
  localparam logic [CNT_W-1:0] LD_EMER   = CNT_W'(EMER_T - 1);

  logic             tick;
  phase_t           state;
  phase_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             car_p;
  logic             ped_p;
  logic             emer_p;
  logic             last_ped;
  logic             req_car;
  logic             req_ped;
  logic             req_emer;
  logic             preempt;
  logic             cnt_zero;
  logic [2:0]       grant_sel;
  lamps_t           lamps;

  intersection_phase_arbiter_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // A request counts from the cycle its input is first seen.
  assign req_car  = car_p | car_sensor;
  assign req_ped  = ped_p | ped_sensor;
  assign req_emer = emer_p | emer_signal;
  assign cnt_zero = (cnt == '0);
  assign preempt  = (state == CROSS_GREEN) && (grant != GRANT_EMER) && req_emer;

  // Emergency first; a car/ped tie goes to whichever was not served last.
  always_comb begin
    grant_sel = GRANT_CAR;
    if (req_emer) begin
      grant_sel = GRANT_EMER;
    end else if (req_ped && (!req_car || !last_ped)) begin
      grant_sel = GRANT_PED;
    end
  end

  always_comb begin
    nxt = state;
    if (tick) begin
      case (state)
        MAIN_GREEN:   if (req_emer || ((req_car || req_ped) && cnt_zero)) nxt = MAIN_YELLOW;
        MAIN_YELLOW:  if (cnt_zero) nxt = ALL_RED_A;
        ALL_RED_A:    if (cnt_zero) nxt = CROSS_GREEN;
        CROSS_GREEN:  if (!preempt && cnt_zero && !((grant == GRANT_EMER) && emer_signal))
                        nxt = CROSS_YELLOW;
        CROSS_YELLOW: if (cnt_zero) nxt = ALL_RED_B;
        ALL_RED_B:    if (cnt_zero) nxt = MAIN_GREEN;
        default:      nxt = MAIN_GREEN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= MAIN_GREEN;
      cnt      <= LD_MAIN;
      car_p    <= 1'b0;
      ped_p    <= 1'b0;
      emer_p   <= 1'b0;
      last_ped <= 1'b0;
      grant    <= GRANT_NONE;
      walk     <= 1'b0;
      lamps    <= lamp_decode(MAIN_GREEN);
      busy     <= 1'b0;
    end else begin
      state  <= nxt;
      lamps  <= lamp_decode(nxt);
      busy   <= (nxt != MAIN_GREEN);
      car_p  <= req_car;
      ped_p  <= req_ped;
      emer_p <= req_emer;
      if (nxt != state) begin
        case (nxt)
          MAIN_YELLOW:  cnt <= LD_YELLOW;
          ALL_RED_A:    cnt <= LD_ALLRED;
          CROSS_GREEN: begin
            grant <= grant_sel;
            walk  <= (grant_sel == GRANT_PED);
            case (grant_sel)
              GRANT_EMER: begin cnt <= LD_EMER; emer_p <= 1'b0; end
              GRANT_PED:  begin cnt <= LD_PED;  ped_p  <= 1'b0; last_ped <= 1'b1; end
              default:    begin cnt <= LD_CAR;  car_p  <= 1'b0; last_ped <= 1'b0; end
            endcase
          end
          CROSS_YELLOW: begin cnt <= LD_YELLOW; walk <= 1'b0; end
          ALL_RED_B:    begin cnt <= LD_ALLRED; grant <= GRANT_NONE; end
          default:      cnt <= LD_MAIN;
        endcase
      end else if (preempt) begin
        // Preempted source goes back in the queue; emergency now owns the cross phase.
        grant  <= GRANT_EMER;
        walk   <= 1'b0;
        cnt    <= LD_EMER;
        emer_p <= 1'b0;
        if (grant == GRANT_PED) ped_p <= 1'b1;
        else                    car_p <= 1'b1;
      end else if (tick && !cnt_zero) begin
        cnt <= cnt - CNT_W'(1);
      end
      // The vehicle being served must not queue a second emergency phase.
      if ((state == CROSS_GREEN) && (grant == GRANT_EMER)) emer_p <= 1'b0;
    end
  end

  assign R1 = lamps.r1;
  assign Y1 = lamps.y1;
  assign G1 = lamps.g1;
  assign R2 = lamps.r2;
  assign Y2 = lamps.y2;
  assign G2 = lamps.g2;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Directed and randomized bench for intersection_phase_arbiter against a tick-counting phase model.
module tb_intersection_phase_arbiter;

  localparam int TD    = 2;
  localparam int MIN_T = 4;
  localparam int YEL_T = 2;
  localparam int AR_T  = 1;
  localparam int CAR_T = 3;
  localparam int PED_T = 2;
  localparam int EM_T  = 3;

  localparam int P_MG = 0, P_MY = 1, P_ARA = 2, P_CG = 3, P_CY = 4, P_ARB = 5;
  localparam logic [2:0] G_CAR = 3'b001, G_PED = 3'b010, G_EMER = 3'b100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       car_sensor = 1'b0;
  logic       ped_sensor = 1'b0;
  logic       emer_signal = 1'b0;
  logic       R1, Y1, G1, R2, Y2, G2, walk, busy;
  logic [2:0] grant;

  intersection_phase_arbiter #(
    .TICK_DIV (TD), .MAIN_MIN_T (MIN_T), .YELLOW_T (YEL_T), .ALLRED_T (AR_T),
    .CAR_GREEN_T (CAR_T), .PED_WALK_T (PED_T), .EMER_T (EM_T), .CNT_W (8)
  ) dut (
    .clk (clk), .reset (reset), .car_sensor (car_sensor), .ped_sensor (ped_sensor),
    .emer_signal (emer_signal), .R1 (R1), .Y1 (Y1), .G1 (G1), .R2 (R2), .Y2 (Y2), .G2 (G2),
    .walk (walk), .grant (grant), .busy (busy)
  );

  always #5 clk = ~clk;

  // Model: current phase, ticks already spent in it, clocks since reset, queued requests.
  int         m_phase, m_el, m_k;
  bit         m_car, m_ped, m_emer, m_last_ped, m_walk;
  logic [2:0] m_grant;
  int         vectors = 0;
  int         misses = 0;

  function automatic int phase_len(input int ph, input logic [2:0] g);
    case (ph)
      P_MG:        return MIN_T;
      P_MY, P_CY:  return YEL_T;
      P_ARA, P_ARB: return AR_T;
      default:     return (g == G_EMER) ? EM_T : (g == G_PED) ? PED_T : CAR_T;
    endcase
  endfunction

  function automatic logic [5:0] lamps_of(input int ph);
    case (ph)
      P_MG:    return 6'b001_100;
      P_MY:    return 6'b010_100;
      P_CG:    return 6'b100_001;
      P_CY:    return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = P_MG; m_el = 0; m_k = 0;
    m_car = 0; m_ped = 0; m_emer = 0; m_last_ped = 0; m_walk = 0; m_grant = 3'b000;
  endtask

  task automatic model_edge(input bit c, input bit p, input bit e);
    bit tk, rc, rp, re, nc, np, ne, adv;
    tk = (m_k > 0) && (m_k % TD == 0);
    m_k++;
    rc = m_car | c; rp = m_ped | p; re = m_emer | e;
    nc = rc; np = rp; ne = re; adv = 0;
    if (m_phase == P_CG && m_grant == G_EMER) ne = 0;
    if (m_phase == P_MG) begin
      if (tk) begin
        if (re || ((rc || rp) && m_el >= MIN_T - 1)) adv = 1; else m_el++;
      end
    end else if (m_phase == P_CG && m_grant != G_EMER && re) begin
      if (m_grant == G_PED) np = 1; else nc = 1;
      m_grant = G_EMER; m_walk = 0; m_el = 0; ne = 0;
    end else if (tk) begin
      if (m_el >= phase_len(m_phase, m_grant) - 1 && !(m_phase == P_CG && m_grant == G_EMER && e))
        adv = 1;
      else
        m_el++;
    end
    if (adv) begin
      m_phase = (m_phase + 1) % 6;
      m_el = 0;
      if (m_phase == P_CG) begin
        if (re) begin m_grant = G_EMER; ne = 0; end
        else if (rp && rc) m_grant = m_last_ped ? G_CAR : G_PED;
        else if (rp) m_grant = G_PED;
        else m_grant = G_CAR;
        if (m_grant == G_PED) begin np = 0; m_last_ped = 1; end
        if (m_grant == G_CAR) begin nc = 0; m_last_ped = 0; end
        m_walk = (m_grant == G_PED);
      end
      if (m_phase == P_CY) m_walk = 0;
      if (m_phase == P_ARB) m_grant = 3'b000;
    end
    m_car = nc; m_ped = np; m_emer = ne;
  endtask

  task automatic check_outputs();
    logic [10:0] obs, exp;
    logic        conflict, onehot;
    obs = {R1, Y1, G1, R2, Y2, G2, walk, grant, busy};
    exp = {lamps_of(m_phase), m_walk, m_grant, 1'(m_phase != P_MG)};
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL outputs t=%0t obs=%b exp=%b (R1Y1G1R2Y2G2 walk grant busy)", $time, obs, exp);
    end
    conflict = (G1 | Y1) & (G2 | Y2);
    vectors++;
    assert (conflict === 1'b0) else begin
      misses++;
      $error("FAIL conflict t=%0t obs=%b exp=0", $time, conflict);
    end
    onehot = $onehot({R1, Y1, G1}) && $onehot({R2, Y2, G2});
    vectors++;
    assert (onehot === 1'b1) else begin
      misses++;
      $error("FAIL lamp_onehot t=%0t obs=%b exp=1", $time, onehot);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit p, input bit e);
    reset = r; car_sensor = c; ped_sensor = p; emer_signal = e;
    @(posedge clk);
    if (!r) model_reset(); else model_edge(c, p, e);
    #1;
    check_outputs();
  endtask

  task automatic wait_grant(input logic [2:0] g, input bit e, input int budget, input string tag);
    int n = 0;
    while (grant !== g && n < budget) begin
      step(1, 0, 0, e);
      n++;
    end
    vectors++;
    assert (grant === g) else begin
      misses++;
      $error("FAIL %s grant obs=%b exp=%b after %0d clks", tag, grant, g, n);
    end
  endtask

  initial begin
    bit e_lvl = 0;
    model_reset();
    // Reset held, then an idle stretch that must stay in main green.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(1, 0, 0, 0);
    vectors++;
    assert ({G1, R2, busy} === 3'b110) else begin
      misses++; $error("FAIL idle_main obs=%b exp=110", {G1, R2, busy});
    end
    // Single car pulse.
    step(1, 1, 0, 0);
    wait_grant(G_CAR, 0, 100, "car_grant");
    for (int i = 0; i < 40; i++) step(1, 0, 0, 0);
    // Car and ped together: ped first, car next round.
    step(1, 1, 1, 0);
    wait_grant(G_PED, 0, 100, "tie_ped_first");
    vectors++;
    assert (walk === 1'b1) else begin
      misses++; $error("FAIL tie_walk obs=%b exp=1", walk);
    end
    wait_grant(G_CAR, 0, 100, "tie_car_next");
    for (int i = 0; i < 40; i++) step(1, 0, 0, 0);
    // Emergency held well past its minimum.
    wait_grant(G_EMER, 1, 100, "emer_grant");
    for (int i = 0; i < 20; i++) step(1, 0, 0, 1);
    vectors++;
    assert (G2 === 1'b1) else begin
      misses++; $error("FAIL emer_hold G2 obs=%b exp=1", G2);
    end
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0);
    // Emergency preempts a pedestrian phase; ped is served again later.
    step(1, 0, 1, 0);
    wait_grant(G_PED, 0, 100, "ped_grant");
    step(1, 0, 0, 1);
    vectors++;
    assert ({walk, grant} === {1'b0, G_EMER}) else begin
      misses++; $error("FAIL preempt obs=%b exp=0100", {walk, grant});
    end
    step(1, 0, 0, 0);
    wait_grant(G_PED, 0, 150, "ped_reserved");
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0);
    // Reset in the middle of a car phase.
    step(1, 1, 0, 0);
    wait_grant(G_CAR, 0, 100, "car_before_reset");
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    vectors++;
    assert ({G1, R2, grant, walk, busy} === 7'b11_000_00) else begin
      misses++; $error("FAIL mid_reset obs=%b exp=1100000", {G1, R2, grant, walk, busy});
    end
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (e_lvl) begin if ($urandom_range(0, 14) == 0) e_lvl = 0; end
      else if ($urandom_range(0, 149) == 0) e_lvl = 1;
      step(($urandom_range(0, 599) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 29) == 0), e_lvl);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
